// File: rtl/seg7_multi_display.sv
// Registered N-digit BCD to seven-segment driver: latched digits, optional leading-zero
// blanking, per-digit blinking, parallel segment buses and a common-anode scan bus.
module seg7_multi_display #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int SCAN_DIV   = 50_000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask_in,
    input  logic                    blank_en,
    output logic                    load_ack,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic [6:0]              scan_seg,
    output logic [NUM_DIGITS-1:0]   scan_an
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] digits_p0;
    logic [NUM_DIGITS-1:0]   mask_p0;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic [SW-1:0]           scan_cnt;
    logic [IW-1:0]           scan_idx;
    logic [7*NUM_DIGITS-1:0] seg_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Walk from the most significant digit down; 'lead' stays set while every
    // digit seen so far is zero or a non-BCD (blank) code.
    always_comb begin
        logic       lead;
        logic [3:0] d;
        logic [6:0] s;
        lead     = 1'b1;
        d        = 4'd0;
        s        = 7'h7F;
        seg_next = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            d = digits_p0[4*i +: 4];
            s = decode(d);
            if (BLANK_LZ != 0 && blank_en && lead && i > 0 && d == 4'd0)
                s = 7'h7F;
            lead = lead && (d == 4'd0 || d > 4'd9);
            if (blink_phase && mask_p0[i])
                s = 7'h7F;
            seg_next[7*i +: 7] = s;
        end
    end

    // Stage boundary: shadow registers and counters feed one registered output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_p0   <= '1;
            mask_p0     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            scan_cnt    <= '0;
            scan_idx    <= '0;
            load_ack    <= 1'b0;
            seg_out     <= '1;
            scan_seg    <= 7'h7F;
            scan_an     <= '1;
        end else begin
            if (load) begin
                digits_p0 <= digits_in;
                mask_p0   <= blink_mask_in;
            end
            load_ack <= load;

            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                if (scan_idx == IW'(NUM_DIGITS - 1))
                    scan_idx <= '0;
                else
                    scan_idx <= scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            // scan_an and scan_seg both come from the pre-edge index so they stay aligned.
            seg_out  <= seg_next;
            scan_seg <= seg_next[7*scan_idx +: 7];
            scan_an  <= ~(NUM_DIGITS'(1) << scan_idx);
        end
    end

endmodule

// File: tb/tb_seg7_multi_display.sv
// Scoreboard bench for seg7_multi_display (4 digits, BLINK_DIV=4, SCAN_DIV=2).
module tb_seg7_multi_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SB = 7'h7F;
    localparam logic [27:0] E1234 = {S1, S2, S3, S4};
    localparam logic [27:0] EBLNK = {SB, SB, SB, SB};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  blink_mask_in;
    logic        blank_en;
    logic        load_ack;
    logic [27:0] seg_out;
    logic [6:0]  scan_seg;
    logic [3:0]  scan_an;

    seg7_multi_display #(
        .NUM_DIGITS(4), .BLINK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
        .blink_mask_in(blink_mask_in), .blank_en(blank_en), .load_ack(load_ack),
        .seg_out(seg_out), .scan_seg(scan_seg), .scan_an(scan_an)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [27:0] val;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    function automatic string kname(input int k);
        case (k)
            0:       return "seg_out";
            1:       return "scan_an";
            2:       return "load_ack";
            default: return "scan_seg";
        endcase
    endfunction

    task automatic push(input int c, input int k, input logic [27:0] v);
        exp_t e;
        e.cyc = c;
        e.kind = k;
        e.val = v;
        q.push_back(e);
    endtask

    // Monitor: pops every expectation due at the current cycle.
    exp_t        me;
    logic [27:0] act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            me = q.pop_front();
            case (me.kind)
                0:       act = seg_out;
                1:       act = {24'd0, scan_an};
                2:       act = {27'd0, load_ack};
                default: act = {21'd0, scan_seg};
            endcase
            total++;
            if (me.cyc != cyc || act !== me.val) begin
                bad++;
                $display("FAIL %s cyc=%0d (now %0d) got=%h want=%h",
                         kname(me.kind), me.cyc, cyc, act, me.val);
            end
        end
    end

    // Scan alignment: scan_seg must equal the seg_out slice of the enabled digit.
    logic [6:0] scan_exp;
    always @(negedge clk) begin
        if (scan_an != 4'b1111) begin
            scan_exp = 7'h7F;
            for (int k = 0; k < 4; k++)
                if (scan_an[k] == 1'b0) scan_exp = seg_out[7*k +: 7];
            total++;
            if (scan_seg !== scan_exp) begin
                bad++;
                $display("FAIL scan align cyc=%0d an=%b got=%h want=%h",
                         cyc, scan_an, scan_seg, scan_exp);
            end
        end
    end

    // Pulse load for one edge; ack follows that edge, seg_out one edge later.
    task automatic do_load(input logic [15:0] d, input logic [3:0] m, input logic [27:0] ex);
        int c;
        c = cyc;
        load = 1'b1;
        digits_in = d;
        blink_mask_in = m;
        push(c + 1, 2, 28'd1);
        push(c + 2, 0, ex);
        push(c + 2, 2, 28'd0);
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    logic [3:0] an_t [8];
    logic [6:0] sg_t [8];

    initial begin
        an_t = '{4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110, 4'b1110};
        sg_t = '{S3, S3, S2, S2, S1, S1, S4, S4};

        rst_n = 1'b0;
        load = 1'b1;
        digits_in = 16'h1234;
        blink_mask_in = 4'b0000;
        blank_en = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            push(c, 0, EBLNK);
            push(c, 1, 28'hF);
            push(c, 2, 28'd0);
        end
        repeat (3) @(negedge clk);

        // Reset must have overridden the held load.
        rst_n = 1'b1;
        push(4, 0, EBLNK);
        do_load(16'h1234, 4'b0000, E1234);

        for (int i = 0; i < 8; i++) begin
            push(6 + i, 1, {24'd0, an_t[i]});
            push(6 + i, 3, {21'd0, sg_t[i]});
        end
        while (cyc < 13) @(negedge clk);

        blank_en = 1'b1;
        do_load(16'h0050, 4'b0000, {SB, SB, S5, S0});
        do_load(16'h0000, 4'b0000, {SB, SB, SB, S0});
        blank_en = 1'b0;
        push(18, 0, {S0, S0, S0, S0});
        @(negedge clk);
        blank_en = 1'b1;
        do_load(16'hF012, 4'b0000, {SB, SB, S1, S2});
        do_load(16'h1020, 4'b0000, {S1, S0, S2, S0});
        blank_en = 1'b0;

        // Blink phase toggles at edges 7,11,...; digit0 dark on edges 24..27 and 32..33.
        do_load(16'h1234, 4'b0001, {S1, S2, S3, SB});
        for (int e = 25; e <= 33; e++)
            push(e, 0, (e <= 27 || e >= 32) ? {S1, S2, S3, SB} : E1234);
        while (cyc < 33) @(negedge clk);

        rst_n = 1'b0;
        push(34, 0, EBLNK);
        push(34, 1, 28'hF);
        push(34, 2, 28'd0);
        @(negedge clk);

        // After reset the blink counter restarts: lit 36..38, dark 39..42.
        rst_n = 1'b1;
        push(35, 1, 28'hE);
        push(35, 3, {21'd0, SB});
        do_load(16'h1234, 4'b0001, E1234);
        for (int e = 37; e <= 42; e++)
            push(e, 0, (e <= 38) ? E1234 : {S1, S2, S3, SB});
        while (cyc < 42) @(negedge clk);

        load = 1'b1;
        digits_in = 16'hABCD;
        blink_mask_in = 4'b0000;
        for (int e = 43; e <= 48; e++) begin
            push(e, 2, (e <= 47) ? 28'd1 : 28'd0);
            if (e >= 44) push(e, 0, EBLNK);
        end
        repeat (5) @(negedge clk);
        load = 1'b0;

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        while (q.size() > 0) begin
            me = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s cyc=%0d never checked got=none want=%h", kname(me.kind), me.cyc, me.val);
        end

        if (bad == 0)
            $display("PASS: all %0d checks passed", total);
        else
            $display("FAILED: %0d of %0d checks failed", bad, total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
